alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Hardware built-in self-test engine for the combinational ALU. It is the initiator end of the ALU interface: it drives alu_a, alu_b and alu_op, and consumes alu_out.
- It sweeps every opcode with corner-case and pseudo-random operands and compresses all results into a MISR signature.
- It compares that signature against a golden value and reports pass/fail.
- It sits beside the datapath ALU. During a run, bist_sel steers the ALU input muxes to this block.

Parameters:
- WIDTH, 32, operand/result width
- OP_W, 5, alu_op width
- NUM_OPS, 12, opcodes exercised (0..NUM_OPS-1)
- VEC_PER_OP, 64, vectors per opcode (>=3)
- LFSR_SEED, 32'hACE1_2468, operand LFSR seed (non-zero)
- GOLDEN_SIG, 32'h0000_0000, expected final MISR value, set at integration from the reference model

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled in IDLE or DONE
- alu_a  out  WIDTH  ALU operand A (registered)
- alu_b  out  WIDTH  ALU operand B (registered)
- alu_op  out  OP_W  ALU opcode (registered)
- alu_out  in  WIDTH  ALU result, combinational from the driven operands
- bist_sel  out  1  steers ALU input muxes to BIST; equals busy
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or reset
- pass  out  1  valid only with done; 1 when signature==GOLDEN_SIG
- signature  out  WIDTH  current MISR value

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - alu_a, alu_b, alu_op, signature, busy, done, pass, bist_sel are all 0.
  - LFSR is set to LFSR_SEED; counters are 0.
- States:
  - IDLE: start=1 at an edge -> RUN.
  - RUN: runs until the last vector is captured -> DONE.
  - DONE: start=1 -> RUN (restart).
  - start in RUN is ignored.
- Run start edge (edge 0):
  - MISR cleared to 0; LFSR loaded with LFSR_SEED; op_cnt=0, vec_cnt=0.
  - Vector 0 of op 0 is driven.
- Vector selection, by vec_cnt within the current op:
  - vec 0: a=32'hFFFF_FFFF, b=32'h0000_0004.
  - vec 1: a=32'h8000_0000, b=32'hFFFF_FFFF.
  - vec >=2: a=lfsr, b={lfsr[15:0],lfsr[31:16]}. LFSR steps once after each such vector is issued.
  - The LFSR is not reseeded per op.
- LFSR: 32-bit Galois, polynomial 32'h8020_0003; shift right, XOR taps when lsb=1.
- Each RUN edge:
  - MISR <= {misr[30:0],1'b0} ^ (misr[31] ? 32'h04C1_1DB7 : 0) ^ alu_out, using the vector driven during the cycle just ended.
  - Then the next vector is driven. vec_cnt wraps at VEC_PER_OP-1 and op_cnt increments.
- Latency: alu_out is captured exactly one cycle after its operands are registered. No ALU pipeline is supported.
- Termination:
  - The vector with op=NUM_OPS-1, vec=VEC_PER_OP-1 is captured at edge N=NUM_OPS*VEC_PER_OP (768 by default).
  - At that edge: state -> DONE, busy=0, done=1, pass=(misr_next==GOLDEN_SIG), alu_a/alu_b/alu_op return to 0.
  - busy is high for exactly N cycles.
- done and pass are cleared on the restart edge.
- signature holds its final value in DONE and is visible throughout the run.
- Reset mid-run aborts immediately to IDLE with all outputs 0. No partial result is retained.
- alu_op is zero-extended from op_cnt; opcodes are never skipped or reordered.

Decomposition:
- Shared package alu_bist_pkg:
  - state enum {IDLE, RUN, DONE}
  - LFSR_POLY, MISR_POLY
  - CORNER_A0/B0/A1/B1 constants
- One sub-module: bist_misr (clear, enable, data_in, sig_out), reusable by future register-file BIST.
- LFSR step is a function in the package.

Test Plan:
- Reset with rst_n=0 mid-sim -> all outputs 0, bist_sel=0; after release, idle with no start -> outputs stay 0.
- One-cycle start pulse against the ALU model:
  - busy=1 for exactly 768 cycles.
  - Cycle 1: op=0, a=FFFFFFFF, b=4.
  - Cycle 2: a=80000000, b=FFFFFFFF.
  - Cycle 3: a=ACE12468, b=2468ACE1.
  - op=1 first appears at cycle 65; op=11 spans cycles 705..768.
  - Then done=1, busy=0.
- GOLDEN_SIG set to the bench model's computed signature -> done=1, pass=1, signature==GOLDEN_SIG. Second run via start in DONE -> identical signature, pass=1.
- Fault injection: bench XORs alu_out[0] on op 3 vec 10 only -> done=1, pass=0, signature!=GOLDEN_SIG. Stuck-at-0 on alu_out[31] for all vectors -> pass=0.
- start held high for 10 cycles during RUN -> no restart, still 768 busy cycles.
- rst_n pulsed low at vector 300 -> immediate IDLE, all outputs 0. Next start -> full run, pass=1.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared types, constants and step functions for the ALU BIST engine.
// Holds the FSM state enum, LFSR/MISR polynomials and corner operands.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  localparam logic [31:0] CORNER_A0 = 32'hFFFF_FFFF;
  localparam logic [31:0] CORNER_B0 = 32'h0000_0004;
  localparam logic [31:0] CORNER_A1 = 32'h8000_0000;
  localparam logic [31:0] CORNER_B1 = 32'hFFFF_FFFF;

  // Galois LFSR, right shift, taps folded in when lsb is 1
  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ LFSR_POLY;
    return r;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold msb via POLY, XOR data.
// Ports: clk, rst_n, clear_i, enable_i, data_in_i, sig_out_o, sig_next_o.
module bist_misr #(
  parameter int            W    = 32,
  parameter logic [W-1:0]  POLY = W'(32'h04C1_1DB7)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] data_in_i,
  output logic [W-1:0] sig_out_o,
  output logic [W-1:0] sig_next_o
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic [W-1:0] step;

  always_comb begin
    step = {sig_q[W-2:0], 1'b0};
    if (sig_q[W-1]) step = step ^ POLY;
    step = step ^ data_in_i;
  end

  always_comb begin
    sig_d = sig_q;
    if (clear_i) sig_d = '0;
    else if (enable_i) sig_d = step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig_out_o  = sig_q;
  // value the register takes at this edge when enabled
  assign sig_next_o = step;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test: sweeps every opcode with corner and LFSR operands,
// compresses results in a MISR. Ports: clk, rst_n, start, alu_a/b/op/out,
// bist_sel, busy, done, pass, signature.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               OP_W       = 5,
  parameter int               NUM_OPS    = 12,
  parameter int               VEC_PER_OP = 64,
  parameter logic [31:0]      LFSR_SEED  = 32'hACE1_2468,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             bist_sel,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam int OPC_W = $clog2(NUM_OPS);
  localparam int VEC_W = $clog2(VEC_PER_OP);

  localparam logic [OPC_W-1:0] LAST_OP =
    OPC_W'(NUM_OPS - 1);
  localparam logic [VEC_W-1:0] LAST_VEC =
    VEC_W'(VEC_PER_OP - 1);

  state_e state_q, state_d;

  logic [OPC_W-1:0] op_q, op_d, op_n;
  logic [VEC_W-1:0] vec_q, vec_d, vec_n;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  opo_q, opo_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             misr_clr;
  logic             misr_en;
  logic [WIDTH-1:0] misr_next;
  logic             last_vec;

  bist_misr #(
    .W    (WIDTH),
    .POLY (WIDTH'(MISR_POLY))
  ) u_misr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (misr_clr),
    .enable_i   (misr_en),
    .data_in_i  (alu_out),
    .sig_out_o  (signature),
    .sig_next_o (misr_next)
  );

  assign last_vec = (op_q == LAST_OP)
                 && (vec_q == LAST_VEC);

  // position of the vector to issue after the current one
  always_comb begin
    vec_n = vec_q + VEC_W'(1);
    op_n  = op_q;
    if (vec_q == LAST_VEC) begin
      vec_n = '0;
      op_n  = op_q + OPC_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    vec_d    = vec_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    b_d      = b_q;
    opo_d    = opo_q;
    done_d   = done_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
          lfsr_d   = LFSR_SEED;
          op_d     = '0;
          vec_d    = '0;
          a_d      = WIDTH'(CORNER_A0);
          b_d      = WIDTH'(CORNER_B0);
          opo_d    = '0;
        end
      end
      RUN: begin
        misr_en = 1'b1;
        if (last_vec) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (misr_next == GOLDEN_SIG);
          a_d     = '0;
          b_d     = '0;
          opo_d   = '0;
        end else begin
          op_d  = op_n;
          vec_d = vec_n;
          opo_d = OP_W'(op_n);
          unique case (1'b1)
            (vec_n == '0): begin
              a_d = WIDTH'(CORNER_A0);
              b_d = WIDTH'(CORNER_B0);
            end
            (vec_n == VEC_W'(1)): begin
              a_d = WIDTH'(CORNER_A1);
              b_d = WIDTH'(CORNER_B1);
            end
            default: begin
              a_d    = WIDTH'(lfsr_q);
              b_d    = WIDTH'({lfsr_q[15:0],
                               lfsr_q[31:16]});
              lfsr_d = lfsr_step(lfsr_q);
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      vec_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      a_q     <= '0;
      b_q     <= '0;
      opo_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opo_q   <= opo_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = opo_q;
  assign busy     = (state_q == RUN);
  assign bist_sel = busy;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed testbench for alu_bist with a reference ALU and signature model.
// Covers reset, vector order, golden pass, fault detection, restart, abort.
module tb_alu_bist;

  localparam int N = 768;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  function automatic logic [31:0] m_lfsr(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [31:0] m_alu(
    input logic [4:0] op, input logic [31:0] a, input logic [31:0] b
  );
    logic [31:0] r;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = {31'b0, $signed(a) < $signed(b)};
      5'd9:  r = {31'b0, a < b};
      5'd10: r = b;
      5'd11: r = ~(a | b);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] m_misr(
    input logic [31:0] m, input logic [31:0] d
  );
    logic [31:0] r;
    r = {m[30:0], 1'b0};
    if (m[31]) r = r ^ 32'h04C1_1DB7;
    return r ^ d;
  endfunction

  function automatic logic [31:0] m_golden();
    logic [31:0] l, m, a, b;
    l = SEED;
    m = 32'h0;
    for (int o = 0; o < 12; o++) begin
      for (int v = 0; v < 64; v++) begin
        if (v == 0) begin
          a = 32'hFFFF_FFFF; b = 32'h0000_0004;
        end else if (v == 1) begin
          a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        end else begin
          a = l; b = {l[15:0], l[31:16]};
          l = m_lfsr(l);
        end
        m = m_misr(m, m_alu(5'(o), a, b));
      end
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD = m_golden();

  logic        clk, rst_n, start;
  logic [31:0] alu_a, alu_b, alu_out, signature;
  logic [4:0]  alu_op;
  logic        bist_sel, busy, done, pass;

  logic        flt1, flt31;
  logic [31:0] fa, fb;

  logic [31:0] ma [N];
  logic [31:0] mb [N];
  logic [4:0]  mo [N];
  logic [31:0] oa [N];
  logic [31:0] ob [N];
  logic [4:0]  oo [N];

  int errors, checks;
  int nb, vm;

  alu_bist #(.GOLDEN_SIG(GOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .bist_sel  (bist_sel),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out = m_alu(alu_op, alu_a, alu_b);
    if (flt1 && alu_op == 5'd3 && alu_a == fa && alu_b == fb)
      alu_out[0] = ~alu_out[0];
    if (flt31) alu_out[31] = 1'b0;
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [127:0] outs();
    return {alu_a, alu_b, alu_op, signature,
            busy, done, pass, bist_sel};
  endfunction

  // Pulse start, then watch every busy cycle; optional start hold / abort.
  task automatic do_run(input int hold_at, input int abort_at,
                        output int nbusy, output int vmis);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    vmis  = 0;
    while (busy === 1'b1 && nbusy < 2000) begin
      if (nbusy < N) begin
        oa[nbusy] = alu_a;
        ob[nbusy] = alu_b;
        oo[nbusy] = alu_op;
        if (alu_a !== ma[nbusy] || alu_b !== mb[nbusy]
            || alu_op !== mo[nbusy]) vmis++;
      end else vmis++;
      if (bist_sel !== 1'b1 || done !== 1'b0 || pass !== 1'b0)
        vmis++;
      nbusy++;
      if (hold_at > 0 && nbusy == hold_at) start = 1'b1;
      if (hold_at > 0 && nbusy == hold_at + 10) start = 1'b0;
      if (abort_at > 0 && nbusy == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] l;
    int idx;
    errors = 0; checks = 0;
    start = 1'b0; rst_n = 1'b0;
    flt1 = 1'b0; flt31 = 1'b0;

    l = SEED;
    for (int o = 0; o < 12; o++) begin
      for (int v = 0; v < 64; v++) begin
        idx = o * 64 + v;
        mo[idx] = 5'(o);
        if (v == 0) begin
          ma[idx] = 32'hFFFF_FFFF; mb[idx] = 32'h4;
        end else if (v == 1) begin
          ma[idx] = 32'h8000_0000; mb[idx] = 32'hFFFF_FFFF;
        end else begin
          ma[idx] = l; mb[idx] = {l[15:0], l[31:16]};
          l = m_lfsr(l);
        end
      end
    end
    fa = ma[3 * 64 + 10];
    fb = mb[3 * 64 + 10];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 128'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_outs", outs(), 128'h0);

    do_run(0, 0, nb, vm);
    chk("r1_busy_cycles", 128'(nb), 128'd768);
    chk("r1_vec_seq", 128'(vm), 128'd0);
    chk("c1_a", 128'(oa[0]), 128'hFFFF_FFFF);
    chk("c1_b", 128'(ob[0]), 128'h4);
    chk("c1_op", 128'(oo[0]), 128'h0);
    chk("c2_ab", {96'h0, oa[1]} << 32 | 128'(ob[1]),
        128'h8000_0000_FFFF_FFFF);
    chk("c3_a", 128'(oa[2]), 128'hACE1_2468);
    chk("c3_b", 128'(ob[2]), 128'h2468_ACE1);
    chk("c64_op", 128'(oo[63]), 128'd0);
    chk("c65_op", 128'(oo[64]), 128'd1);
    chk("c704_op", 128'(oo[703]), 128'd10);
    chk("c705_op", 128'(oo[704]), 128'd11);
    chk("c768_op", 128'(oo[767]), 128'd11);
    chk("r1_flags", {125'h0, done, busy, pass}, 128'b101);
    chk("r1_sig", 128'(signature), 128'(GOLD));
    chk("r1_ops_zero", {alu_a, alu_b, alu_op, bist_sel}, 128'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_held", {126'h0, done, pass}, 128'b11);

    do_run(0, 0, nb, vm);
    chk("r2_busy_cycles", 128'(nb), 128'd768);
    chk("r2_vec_seq", 128'(vm), 128'd0);
    chk("r2_sig", 128'(signature), 128'(GOLD));
    chk("r2_flags", {125'h0, done, busy, pass}, 128'b101);

    flt1 = 1'b1;
    do_run(0, 0, nb, vm);
    flt1 = 1'b0;
    chk("f1_done_pass", {126'h0, done, pass}, 128'b10);
    chk("f1_sig_differs", {127'h0, signature !== GOLD}, 128'd1);

    flt31 = 1'b1;
    do_run(0, 0, nb, vm);
    flt31 = 1'b0;
    chk("f31_done_pass", {126'h0, done, pass}, 128'b10);

    do_run(100, 0, nb, vm);
    chk("hold_busy_cycles", 128'(nb), 128'd768);
    chk("hold_vec_seq", 128'(vm), 128'd0);
    chk("hold_pass", {126'h0, done, pass}, 128'b11);

    do_run(0, 300, nb, vm);
    chk("abort_at", 128'(nb), 128'd300);
    chk("abort_outs", outs(), 128'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle", outs(), 128'h0);
    do_run(0, 0, nb, vm);
    chk("post_busy_cycles", 128'(nb), 128'd768);
    chk("post_vec_seq", 128'(vm), 128'd0);
    chk("post_pass", {126'h0, done, pass}, 128'b11);
    chk("post_sig", 128'(signature), 128'(GOLD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
